// File: rtl/morph_window_ctrl.sv
// morph_window_ctrl: frame/line/pixel sequencer for the 3x3 morphology stage.
// Tracks the pixel position from the iFVAL/iDVAL stream, drives the line-buffer
// clock enable, qualifies complete 3x3 windows and delays the qualification so it
// lines up with the datapath output. The morphology mode is latched once per frame.
module morph_window_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int PIPE_LAT = 2,
  parameter int CNT_W    = 11
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             iFVAL,
  input  logic             iDVAL,
  input  logic [1:0]       iMODE,
  input  logic             iCFG_WR,
  output logic             oLB_CLKEN,
  output logic [1:0]       oMODE,
  output logic             oDVAL,
  output logic             oWIN_VALID,
  output logic             oBORDER,
  output logic [CNT_W-1:0] oX,
  output logic [CNT_W-1:0] oY,
  output logic             oFRAME_DONE,
  output logic             oERR
);

  if (PIPE_LAT < 1 || PIPE_LAT > 8) begin : g_bad_lat
    $error("morph_window_ctrl: PIPE_LAT must be in 1..8");
  end

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO    = CNT_W'(2);

  state_t           state;
  logic             fval_q;
  logic [1:0]       pending;
  logic [CNT_W-1:0] x_cnt;
  logic [CNT_W-1:0] y_cnt;
  logic             frame_full;

  logic             fval_rise;
  logic             fval_fall;
  logic             in_active;
  logic             overflow;
  logic             pix_take;
  logic             win_inner;
  logic             win_in;
  logic [CNT_W-1:0] cx_in;
  logic [CNT_W-1:0] cy_in;

  logic             d_dval [PIPE_LAT];
  logic             d_win  [PIPE_LAT];
  logic [CNT_W-1:0] d_x    [PIPE_LAT];
  logic [CNT_W-1:0] d_y    [PIPE_LAT];

  // Input-side decode: frame edges, overflow, clock enable and window qualification.
  // The centre of a window that is not yet complete is undefined, so it is forced to 0.
  always_comb begin
    fval_rise = iFVAL & ~fval_q;
    fval_fall = ~iFVAL & fval_q;
    in_active = (state == ACTIVE);
    overflow  = iDVAL & in_active & frame_full;
    pix_take  = iDVAL & in_active & ~frame_full;
    win_inner = (x_cnt >= TWO) && (y_cnt >= TWO);
    win_in    = iDVAL & in_active & win_inner;
    cx_in     = win_inner ? (x_cnt - ONE) : '0;
    cy_in     = win_inner ? (y_cnt - ONE) : '0;
    oLB_CLKEN = pix_take;
  end

  // Frame FSM with position counters, per-frame mode latch, frame-done pulse and sticky error.
  // frame_full marks that the last pixel of the frame was consumed; counters then hold.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      fval_q      <= 1'b0;
      pending     <= 2'b00;
      oMODE       <= 2'b00;
      x_cnt       <= '0;
      y_cnt       <= '0;
      frame_full  <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oERR        <= 1'b0;
    end else begin
      fval_q      <= iFVAL;
      oFRAME_DONE <= 1'b0;
      if (iCFG_WR) begin
        pending <= iMODE;
      end
      if (overflow || (iDVAL && !in_active)) begin
        oERR <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (fval_rise) begin
            state      <= ACTIVE;
            x_cnt      <= '0;
            y_cnt      <= '0;
            frame_full <= 1'b0;
            oMODE      <= iCFG_WR ? iMODE : pending;
          end
        end
        ACTIVE: begin
          if (pix_take) begin
            if (x_cnt == X_LAST) begin
              if (y_cnt == Y_LAST) begin
                frame_full <= 1'b1;
              end else begin
                x_cnt <= '0;
                y_cnt <= y_cnt + ONE;
              end
            end else begin
              x_cnt <= x_cnt + ONE;
            end
          end
          if (fval_fall) begin
            state       <= DONE;
            oFRAME_DONE <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Free-running delay line so output gaps reproduce input gaps at fixed latency.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        d_dval[i] <= 1'b0;
        d_win[i]  <= 1'b0;
        d_x[i]    <= '0;
        d_y[i]    <= '0;
      end
    end else begin
      d_dval[0] <= iDVAL;
      d_win[0]  <= win_in;
      d_x[0]    <= cx_in;
      d_y[0]    <= cy_in;
      for (int i = 1; i < PIPE_LAT; i++) begin
        d_dval[i] <= d_dval[i-1];
        d_win[i]  <= d_win[i-1];
        d_x[i]    <= d_x[i-1];
        d_y[i]    <= d_y[i-1];
      end
    end
  end

  // Aligned outputs from the last delay stage; border marks valid pixels without a full window.
  always_comb begin
    oDVAL      = d_dval[PIPE_LAT-1];
    oWIN_VALID = d_win[PIPE_LAT-1];
    oX         = d_x[PIPE_LAT-1];
    oY         = d_y[PIPE_LAT-1];
    oBORDER    = oDVAL & ~oWIN_VALID;
  end

endmodule
